// File: rtl/machine_timer_pkg.sv
// Shared types and helpers for the machine timer: register decode and byte-lane merge.
`include "constants.vh"

package machine_timer_pkg;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_MTIME_LO,
    REG_MTIME_HI,
    REG_CMP_LO,
    REG_CMP_HI,
    REG_CTRL
  } reg_sel_e;

  function automatic reg_sel_e decode_off(input logic [31:0] off);
    case (off)
      `MTIMER_MTIME_LO_OFF: return REG_MTIME_LO;
      `MTIMER_MTIME_HI_OFF: return REG_MTIME_HI;
      `MTIMER_CMP_LO_OFF:   return REG_CMP_LO;
      `MTIMER_CMP_HI_OFF:   return REG_CMP_HI;
      `MTIMER_CTRL_OFF:     return REG_CTRL;
      default:              return REG_NONE;
    endcase
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] wr_val,
                                             input logic [3:0]  mask);
    logic [31:0] res;
    res = old_val;
    for (int n = 0; n < 4; n++) begin
      if (mask[n]) res[8*n +: 8] = wr_val[8*n +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/constants.vh
// Register offsets and CTRL field positions of the machine timer.
// These are shared with the bus decoder and the firmware headers.
`ifndef MTIMER_CONSTANTS_VH
`define MTIMER_CONSTANTS_VH

`define MTIMER_MTIME_LO_OFF   32'h00
`define MTIMER_MTIME_HI_OFF   32'h04
`define MTIMER_CMP_LO_OFF     32'h08
`define MTIMER_CMP_HI_OFF     32'h0C
`define MTIMER_CTRL_OFF       32'h10

`define MTIMER_CTRL_EN_BIT    0
`define MTIMER_CTRL_DIV_LSB   8

`endif

// File: rtl/timer_prescaler.sv
// Tick divider for the machine timer, used only when MTIMER_PRESCALER_EN is defined.
// Produces one tick every div+1 enabled cycles; the count sits at 0 while disabled or cleared.
module timer_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [PRESC_W-1:0] div,
  input  logic               clr,
  output logic               tick
);

  logic [PRESC_W-1:0] r_cnt;

  assign tick = en && (r_cnt == div);

  always_ff @(posedge clk) begin
    if (!reset || !en || clr) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/machine_timer.sv
// RISC-V machine timer (mtime/mtimecmp) on the data bus with a level interrupt request.
// Define MTIMER_PRESCALER_EN to add the CTRL.DIV tick prescaler.
`include "constants.vh"

module machine_timer
  import machine_timer_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int PRESC_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sel,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [3:0]        wrMask,
  input  logic [31:0]       wd,
  output logic [31:0]       rd,
  output logic              irq
);

  if (PRESC_W < 1 || PRESC_W > 32 - `MTIMER_CTRL_DIV_LSB) begin : g_presc_w_check
    $error("machine_timer: PRESC_W does not fit in CTRL");
  end

  logic [63:0] r_mtime;
  logic [63:0] r_cmp;
  logic        r_en;
  logic        r_irq;
  logic [31:0] w_off;
  reg_sel_e    w_sel;
  logic        w_wr;
  logic        w_wr_ctrl;
  logic        w_tick;
  logic [31:0] w_ctrl;

  // Byte offset with the sub-word bits dropped; registers are word aligned.
  assign w_off     = 32'(addr & ~ADDR_W'(3));
  assign w_sel     = sel ? decode_off(w_off) : REG_NONE;
  assign w_wr      = sel && we;
  assign w_wr_ctrl = w_wr && (w_sel == REG_CTRL);

`ifdef MTIMER_PRESCALER_EN
  logic [PRESC_W-1:0] r_div;
  logic [PRESC_W-1:0] w_div_new;

  assign w_ctrl = (32'(r_div) << `MTIMER_CTRL_DIV_LSB) | 32'(r_en);

  always_comb begin
    w_div_new = r_div;
    for (int i = 0; i < PRESC_W; i++) begin
      if (wrMask[(`MTIMER_CTRL_DIV_LSB + i) / 8]) w_div_new[i] = wd[`MTIMER_CTRL_DIV_LSB + i];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_div <= '0;
    end else if (w_wr_ctrl) begin
      r_div <= w_div_new;
    end
  end

  timer_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (r_en),
    .div   (r_div),
    .clr   (w_wr_ctrl),
    .tick  (w_tick)
  );
`else
  assign w_ctrl = 32'(r_en);
  assign w_tick = r_en;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mtime <= '0;
      r_cmp   <= '1;
      r_en    <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_irq <= r_en && (r_mtime >= r_cmp);

      // A software write to either mtime half takes the place of that cycle's tick.
      if (w_wr && (w_sel == REG_MTIME_LO)) begin
        r_mtime[31:0] <= byte_merge(r_mtime[31:0], wd, wrMask);
      end else if (w_wr && (w_sel == REG_MTIME_HI)) begin
        r_mtime[63:32] <= byte_merge(r_mtime[63:32], wd, wrMask);
      end else if (w_tick) begin
        r_mtime <= r_mtime + 64'd1;
      end

      if (w_wr && (w_sel == REG_CMP_LO)) r_cmp[31:0]  <= byte_merge(r_cmp[31:0], wd, wrMask);
      if (w_wr && (w_sel == REG_CMP_HI)) r_cmp[63:32] <= byte_merge(r_cmp[63:32], wd, wrMask);

      if (w_wr_ctrl && wrMask[`MTIMER_CTRL_EN_BIT / 8]) r_en <= wd[`MTIMER_CTRL_EN_BIT];
    end
  end

  always_comb begin
    rd = '0;
    case (w_sel)
      REG_MTIME_LO: rd = r_mtime[31:0];
      REG_MTIME_HI: rd = r_mtime[63:32];
      REG_CMP_LO:   rd = r_cmp[31:0];
      REG_CMP_HI:   rd = r_cmp[63:32];
      REG_CTRL:     rd = w_ctrl;
      default:      rd = '0;
    endcase
  end

  assign irq = r_irq;

endmodule

// File: tb/tb_machine_timer.sv
// Bench for machine_timer: directed scenarios plus random bus traffic, scored against a
// cycle-level register model; expectations are queued by the driver and popped by a monitor.
module tb_machine_timer;

  localparam int ADDR_W  = 5;
  localparam int PRESC_W = 8;

  localparam logic [4:0] A_LO   = 5'h00;
  localparam logic [4:0] A_HI   = 5'h04;
  localparam logic [4:0] A_CLO  = 5'h08;
  localparam logic [4:0] A_CHI  = 5'h0C;
  localparam logic [4:0] A_CTRL = 5'h10;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              sel = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic              we = 1'b0;
  logic [3:0]        wrMask = '0;
  logic [31:0]       wd = '0;
  logic [31:0]       rd;
  logic              irq;

  always #5 clk = ~clk;

  machine_timer #(
    .ADDR_W  (ADDR_W),
    .PRESC_W (PRESC_W)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .sel    (sel),
    .addr   (addr),
    .we     (we),
    .wrMask (wrMask),
    .wd     (wd),
    .rd     (rd),
    .irq    (irq)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] q_rd[$];
  logic        q_irq[$];

  // Reference model: architectural register state after the most recent clock edge.
  logic [63:0] m_time;
  logic [63:0] m_cmp;
  logic        m_en;
  logic        m_irq;
  bit          m_known = 1'b0;
`ifdef MTIMER_PRESCALER_EN
  logic [7:0]  m_div;
  int          m_since;
`endif

  function automatic logic [31:0] lanes(input logic [31:0] old_v, input logic [3:0] m,
                                        input logic [31:0] d);
    logic [31:0] r;
    r = old_v;
    for (int n = 0; n < 4; n++) if (m[n]) r[8*n +: 8] = d[8*n +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ctrl_val();
`ifdef MTIMER_PRESCALER_EN
    return {16'h0, m_div, 7'h0, m_en};
`else
    return {31'h0, m_en};
`endif
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a & 5'h1C)
      A_LO:    return m_time[31:0];
      A_HI:    return m_time[63:32];
      A_CLO:   return m_cmp[31:0];
      A_CHI:   return m_cmp[63:32];
      A_CTRL:  return ctrl_val();
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge(input logic rst_n, input logic s, input logic w,
                            input logic [4:0] a, input logic [3:0] m, input logic [31:0] d);
    logic        wr;
    logic        tick;
    logic        irq_next;
    logic [4:0]  off;
    logic [31:0] c;
    if (!rst_n) begin
      m_time = 64'h0; m_cmp = '1; m_en = 1'b0; m_irq = 1'b0; m_known = 1'b1;
`ifdef MTIMER_PRESCALER_EN
      m_div = 8'h0; m_since = 0;
`endif
      return;
    end
    wr  = s && w;
    off = a & 5'h1C;
`ifdef MTIMER_PRESCALER_EN
    // One tick per DIV+1 enabled cycles, counted since enable or the last CTRL write.
    tick = m_en && ((m_since % (int'(m_div) + 1)) == int'(m_div));
    if (!m_en || (wr && off == A_CTRL)) m_since = 0;
    else m_since = tick ? 0 : m_since + 1;
`else
    tick = m_en;
`endif
    irq_next = m_en && (m_time >= m_cmp);
    if (wr && off == A_LO)      m_time[31:0]  = lanes(m_time[31:0], m, d);
    else if (wr && off == A_HI) m_time[63:32] = lanes(m_time[63:32], m, d);
    else if (tick)              m_time = m_time + 64'd1;
    if (wr && off == A_CLO) m_cmp[31:0]  = lanes(m_cmp[31:0], m, d);
    if (wr && off == A_CHI) m_cmp[63:32] = lanes(m_cmp[63:32], m, d);
    if (wr && off == A_CTRL) begin
      c = lanes(ctrl_val(), m, d);
      m_en = c[0];
`ifdef MTIMER_PRESCALER_EN
      m_div = c[15:8];
`endif
    end
    m_irq = irq_next;
  endtask

  // One bus cycle: drive, queue what the monitor should see this cycle, then advance the model.
  task automatic step(input logic rst_n, input logic s, input logic w, input logic [4:0] a,
                      input logic [3:0] m, input logic [31:0] d,
                      input longint rd_ovr = -1, input int irq_ovr = -1);
    reset = rst_n; sel = s; we = w; addr = a; wrMask = m; wd = d;
    if (rd_ovr >= 0) q_rd.push_back(rd_ovr[31:0]);
    else q_rd.push_back(s ? m_read(a) : 32'h0);
    if (irq_ovr >= 0) q_irq.push_back(irq_ovr[0]);
    else if (m_known) q_irq.push_back(m_irq);
    @(posedge clk);
    model_edge(rst_n, s, w, a, m, d);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    step(1'b1, 1'b1, 1'b1, a, 4'hF, d);
  endtask

  task automatic rdc(input logic [4:0] a, input logic [31:0] exp_v);
    step(1'b1, 1'b1, 1'b0, a, 4'h0, 32'h0, longint'(exp_v));
  endtask

  task automatic idle(input int n, input int irq_exp = -1);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 5'h0, 4'h0, 32'h0, -1, irq_exp);
  endtask

  always @(negedge clk) begin
    logic [31:0] e_rd;
    logic        e_irq;
    if (q_rd.size() > 0) begin
      e_rd = q_rd.pop_front();
      checks++;
      if (rd !== e_rd) begin
        errors++;
        $display("FAIL rd t=%0t sel=%b addr=%h got=%h expected=%h", $time, sel, addr, rd, e_rd);
      end
    end
    if (q_irq.size() > 0) begin
      e_irq = q_irq.pop_front();
      checks++;
      if (irq !== e_irq) begin
        errors++;
        $display("FAIL irq t=%0t got=%b expected=%b", $time, irq, e_irq);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        r_rst;
    logic [31:0] r_d;
    @(posedge clk);
    #1;
    step(1'b0, 1'b0, 1'b0, 5'h0, 4'h0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 5'h0, 4'h0, 32'h0);

    // Reset values, unmapped offsets
    rdc(A_LO, 32'h0); rdc(A_HI, 32'h0);
    rdc(A_CLO, 32'hFFFF_FFFF); rdc(A_CHI, 32'hFFFF_FFFF);
    rdc(A_CTRL, 32'h0); rdc(5'h14, 32'h0); rdc(5'h1C, 32'h0);

    // Free-running count
    wr(A_CTRL, 32'h1);
    idle(10, 0);
    rdc(A_LO, 32'd10);
    rdc(A_HI, 32'd0);

    // Carry into the high word, then full 64-bit wrap
    wr(A_LO, 32'hFFFF_FFFE);
    wr(A_HI, 32'h0);
    idle(2);
    rdc(A_LO, 32'h0);
    rdc(A_HI, 32'h1);
    wr(A_LO, 32'hFFFF_FFFF);
    wr(A_HI, 32'hFFFF_FFFF);
    idle(1);
    rdc(A_LO, 32'h0);
    rdc(A_HI, 32'h0);

    // Compare match timing and clearing by moving CMP
    wr(A_CTRL, 32'h0); wr(A_LO, 32'h0); wr(A_HI, 32'h0);
    wr(A_CLO, 32'd5); wr(A_CHI, 32'h0);
    wr(A_CTRL, 32'h1);
    idle(6, 0);
    idle(1, 1);
    step(1'b1, 1'b1, 1'b1, A_CHI, 4'hF, 32'h1, -1, 1);
    idle(1, 1);
    idle(1, 0);

    // Partial-lane write to MTIME_LO replaces that cycle's tick
    wr(A_CTRL, 32'h0); wr(A_LO, 32'h10); wr(A_HI, 32'h0);
    wr(A_CTRL, 32'h1);
    step(1'b1, 1'b1, 1'b1, A_LO, 4'b0010, 32'h0000_AB00);
    rdc(A_LO, 32'h0000_AB10);
    rdc(A_HI, 32'h0);

    // Prescaler (or its absence)
    wr(A_CTRL, 32'h0); wr(A_LO, 32'h0); wr(A_HI, 32'h0);
    wr(A_CTRL, 32'h301);
    idle(12);
`ifdef MTIMER_PRESCALER_EN
    rdc(A_LO, 32'd3);
    rdc(A_CTRL, 32'h301);
`else
    rdc(A_LO, 32'd12);
    rdc(A_CTRL, 32'h1);
`endif

    // Reset mid-count with irq asserted, colliding with a write
    wr(A_CLO, 32'h0); wr(A_CHI, 32'h0); wr(A_CTRL, 32'h1);
    idle(3);
    idle(1, 1);
    step(1'b0, 1'b1, 1'b1, A_CLO, 4'hF, 32'h0000_0123);
    step(1'b1, 1'b1, 1'b0, A_LO, 4'h0, 32'h0, 0, 0);
    rdc(A_HI, 32'h0); rdc(A_CLO, 32'hFFFF_FFFF); rdc(A_CHI, 32'hFFFF_FFFF); rdc(A_CTRL, 32'h0);

    // Writes without chip select are ignored
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 5'(4 * i), 4'hF, 32'h1234_5601);
    rdc(A_LO, 32'h0); rdc(A_CLO, 32'hFFFF_FFFF); rdc(A_CTRL, 32'h0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      r_rst = ($urandom_range(0, 79) != 0);
      r_d   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom);
      step(r_rst, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           5'($urandom), 4'($urandom), r_d);
    end

    @(negedge clk);
    #1;
    checks++;
    if (q_rd.size() != 0 || q_irq.size() != 0) begin
      errors++;
      $display("FAIL drain: rd queue=%0d irq queue=%0d required 0/0", q_rd.size(), q_irq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
